tp_rx: RTL and testbench
========================

TP_RX -- requirements
Module: tp_rx

Interface
REQ-001 Parameter WIDTH, default 32, number of dual-rail data bits per token.
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of the input rail synchronizer (legal range 2..4).
REQ-003 Parameter DEPTH, default 2, entries in the output buffer (power of two, >=2).
REQ-004 clk  input  1  single block clock; the only clock in the block.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 data  input  [WIDTH-1:0][RAIL_NUM-1:0]  two-phase dual-rail link; rail RAIL_F (0) transition = bit 0, rail RAIL_T (1) transition = bit 1.
REQ-007 ack  output  1  two-phase acknowledge back to the link sender; one toggle per accepted token.
REQ-008 out_data  output  WIDTH  decoded token at buffer head.
REQ-009 out_valid  output  1  buffer head holds a token.
REQ-010 out_ready  input  1  consumer accepts head when out_valid && out_ready at clk rising edge.
REQ-011 err  output  1  sticky protocol error flag.

Function
REQ-012 Each rail SHALL pass through SYNC_STAGES flops before use; s denotes the synchronized rails.
REQ-013 Register ref[WIDTH-1:0][1:0] holds rail values at the last accepted token; delta d = s XOR ref.
REQ-014 bit_done[b] = d[b][0] OR d[b][1]; bit_bad[b] = d[b][0] AND d[b][1]; all_done = AND of bit_done.
REQ-015 FSM states: WAIT, CHECK, HOLD, ERR.
REQ-016 WAIT: any bit_bad -> ERR; else all_done -> CHECK (latch d into d_q); else stay.
REQ-017 CHECK: any bit_bad -> ERR; d != d_q -> stay CHECK, reload d_q; d == d_q and buffer not full -> capture, go WAIT; d == d_q and buffer full -> HOLD.
REQ-018 HOLD: any bit_bad -> ERR; buffer not full (including pop in same cycle) -> capture, go WAIT; else stay.
REQ-019 Capture: push word w[b] = d[b][1] into buffer, ref <= s, ack toggles (registered, visible next cycle).
REQ-020 Latency: all_done first true in cycle N -> CHECK in N+1 -> capture at end of N+1 -> out_valid and ack toggle visible in N+2 (empty buffer).
REQ-021 Buffer full: ack SHALL NOT toggle; sender is back-pressured; no token lost or duplicated.
REQ-022 Simultaneous push and pop on a full buffer SHALL succeed in the same cycle.
REQ-023 Buffer SHALL be first-in first-out; out_data stable while out_valid && !out_ready.
REQ-024 ERR: err = 1, no further captures, ack frozen, buffered tokens still drain; exit only by reset.
REQ-025 Pointer wrap-around on DEPTH boundary SHALL be seamless (no bubble, no duplicate).

Reset
REQ-026 rst_n low: ack = 0, out_valid = 0, out_data = 0, err = 0, ref = 0, sync flops = 0, buffer empty, state WAIT.
REQ-027 Reset mid-token SHALL discard partial deltas; sender link SHALL be at all-zero rails with ack = 0 when rst_n deasserts.
REQ-028 rst_n deassertion SHALL be synchronized to clk before leaving reset state.

Structure
REQ-029 Shared package holds RAIL_NUM = 2, RAIL_F = 0, RAIL_T = 1 and the FSM state typedef.
REQ-030 Output buffer SHALL be a sub-module named tp_rx_fifo (WIDTH, DEPTH; push/full, pop/empty).

Verification
REQ-031 WIDTH=8, token 0xA5 toggles rails with 3-cycle skew spread -> exactly one push, out_data = 0xA5, ack 0->1 once.
REQ-032 Tokens 0x00, 0xFF, 0x3C back-to-back, out_ready = 1 -> outputs 0x00, 0xFF, 0x3C in order; ack toggles 3 times, ends at 1.
REQ-033 out_ready = 0, DEPTH=2, send 3 tokens -> 2 buffered, ack toggles 2 times, third held; raise out_ready -> third captured, all 3 out in order.
REQ-034 Bit 4 toggles both rails -> err = 1 within 2 cycles after sync, no push, ack unchanged; buffered tokens still drain.
REQ-035 rst_n pulsed low with half the bits of a token toggled -> all outputs at reset values; next full token after release decodes correctly.
REQ-036 Send 9 tokens through DEPTH=4 with random out_ready -> no loss, no duplicate across pointer wrap.

Source files
------------

// File: rtl/tp_rx_pkg.sv
// Shared rail indices and FSM state encoding for the two-phase dual-rail receiver.
package tp_rx_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_F   = 0;
    localparam int RAIL_T   = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;
    localparam state_t ST_ERR   = 2'd3;

endpackage

// File: rtl/tp_rx_fifo.sv
// Output token buffer: power-of-two ring with wrap-bit pointers; push and pop may coincide when full.
module tp_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Head reads as zero when empty so the decoded output is clean out of reset.
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tp_rx.sv
// Two-phase dual-rail link receiver: synchronizes rails, detects a complete token,
// waits one cycle for the delta to settle, then decodes it into the output buffer.
module tp_rx
    import tp_rx_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] data,
    output logic                           ack,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           err
);

    logic [1:0]                                        r_rst_sync;
    logic                                              w_rst_n;
    logic [SYNC_STAGES-1:0][WIDTH-1:0][RAIL_NUM-1:0]   r_sync;
    logic [WIDTH-1:0][RAIL_NUM-1:0]                    w_s;
    logic [WIDTH-1:0][RAIL_NUM-1:0]                    w_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0]                    r_ref;
    logic [WIDTH-1:0][RAIL_NUM-1:0]                    r_dq;
    logic [WIDTH-1:0]                                  w_bit_done;
    logic [WIDTH-1:0]                                  w_bit_bad;
    logic [WIDTH-1:0]                                  w_word;
    logic                                              w_all_done;
    logic                                              w_any_bad;
    logic                                              w_full;
    logic                                              w_empty;
    logic                                              w_pop;
    logic                                              w_push;
    logic                                              w_dq_load;
    state_t                                            r_state;
    state_t                                            w_state_nxt;
    logic                                              r_ack;

    // Reset asserts immediately but releases only after two clean clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], data};
    end

    assign w_s = r_sync[SYNC_STAGES-1];
    assign w_d = w_s ^ r_ref;

    always_comb begin
        w_bit_done = '0;
        w_bit_bad  = '0;
        w_word     = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_bit_done[b] = w_d[b][RAIL_F] | w_d[b][RAIL_T];
            w_bit_bad[b]  = w_d[b][RAIL_F] & w_d[b][RAIL_T];
            w_word[b]     = w_d[b][RAIL_T];
        end
    end

    assign w_all_done = &w_bit_done;
    assign w_any_bad  = |w_bit_bad;
    assign w_pop      = out_valid && out_ready;

    // CHECK demands the delta be unchanged for a full cycle so late rail skew cannot corrupt a word.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_dq_load   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_any_bad) begin
                    w_state_nxt = ST_ERR;
                end else if (w_all_done) begin
                    w_state_nxt = ST_CHECK;
                    w_dq_load   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_any_bad) begin
                    w_state_nxt = ST_ERR;
                end else if (w_d != r_dq) begin
                    w_dq_load   = 1'b1;
                end else if (!w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_any_bad) begin
                    w_state_nxt = ST_ERR;
                end else if (!w_full || w_pop) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_WAIT;
            r_ref   <= '0;
            r_dq    <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_dq_load) r_dq <= w_d;
            if (w_push) begin
                r_ref <= w_s;
                r_ack <= ~r_ack;
            end
        end
    end

    tp_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .push      (w_push),
        .push_data (w_word),
        .full      (w_full),
        .pop       (w_pop),
        .empty     (w_empty),
        .pop_data  (out_data)
    );

    assign out_valid = !w_empty;
    assign ack       = r_ack;
    assign err       = (r_state == ST_ERR);

endmodule

// File: tb/tb_tp_rx.sv
// Directed bench for tp_rx: one DEPTH=2 and one DEPTH=4 receiver, each driven by a two-phase sender model.
`timescale 1ns/1ps
module tb_tp_rx;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0][1:0] tx2  = '0;
    logic [7:0][1:0] tx4  = '0;
    logic           rdy2  = 1'b0;
    logic           rdy4  = 1'b0;
    logic           ack2, ack4, vld2, vld4, err2, err4;
    logic [7:0]     od2, od4;

    logic [7:0]     exp2[$];
    logic [7:0]     exp4[$];
    int             n_tot = 0;
    int             n_bad = 0;
    int             tog2  = 0;
    int             tog4  = 0;
    logic           pa2   = 1'b0;
    logic           pa4   = 1'b0;
    logic [7:0]     vec [9] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h99, 8'h66, 8'h0F, 8'hF0};

    always #5 clk = ~clk;

    tp_rx #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(tx2), .ack(ack2), .out_data(od2),
        .out_valid(vld2), .out_ready(rdy2), .err(err2)
    );

    tp_rx #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .data(tx4), .ack(ack4), .out_data(od4),
        .out_valid(vld4), .out_ready(rdy4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? ack2 : ack4;
    endfunction

    function automatic logic get_vld(input int sel);
        return (sel == 0) ? vld2 : vld4;
    endfunction

    // Consumer-side scoreboard and ack toggle counters.
    always @(negedge clk) begin
        if (ack2 !== pa2) tog2++;
        pa2 = ack2;
        if (ack4 !== pa4) tog4++;
        pa4 = ack4;
        if (vld2 && rdy2) begin
            if (exp2.size() == 0) chk("pop2_extra", 32'(exp2.size()), 32'd1);
            else                  chk("pop2_data", 32'(od2), 32'(exp2.pop_front()));
        end
        if (vld4 && rdy4) begin
            if (exp4.size() == 0) chk("pop4_extra", 32'(exp4.size()), 32'd1);
            else                  chk("pop4_data", 32'(od4), 32'(exp4.pop_front()));
        end
    end

    task automatic toggle_bits(input int sel, input logic [7:0] val, input logic [7:0] mask);
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) begin
                if (sel == 0) tx2[b][val[b]] = ~tx2[b][val[b]];
                else          tx4[b][val[b]] = ~tx4[b][val[b]];
            end
        end
    endtask

    task automatic send_token(input int sel, input logic [7:0] val, input bit skew);
        if (sel == 0) exp2.push_back(val);
        else          exp4.push_back(val);
        if (!skew) begin
            @(posedge clk); #1; toggle_bits(sel, val, 8'hFF);
        end else begin
            @(posedge clk); #1; toggle_bits(sel, val, 8'h49);
            @(posedge clk); #1; toggle_bits(sel, val, 8'h92);
            @(posedge clk); #1; toggle_bits(sel, val, 8'h24);
        end
    endtask

    task automatic wait_ack(input int sel, input logic exp, input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (get_ack(sel) == exp) break;
        end
        chk(tag, 32'(get_ack(sel)), 32'(exp));
    endtask

    task automatic drain(input int sel, input string tag);
        @(posedge clk); #1;
        if (sel == 0) rdy2 = 1'b1;
        else          rdy4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!get_vld(sel)) break;
        end
        chk(tag, 32'(get_vld(sel)), 32'd0);
        chk({tag, "_sb"}, (sel == 0) ? 32'(exp2.size()) : 32'(exp4.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic ack_before;
        bit   done;
        done = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack2",  32'(ack2), 32'd0);
        chk("rst_vld2",  32'(vld2), 32'd0);
        chk("rst_data2", 32'(od2),  32'd0);
        chk("rst_err2",  32'(err2), 32'd0);
        chk("rst_ack4",  32'(ack4), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back tokens on DEPTH=4, first one also checks the capture latency.
        tog4 = 0;
        rdy4 = 1'b1;
        send_token(1, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_ack_early", 32'(ack4), 32'd0);
        @(negedge clk);
        chk("lat_ack",  32'(ack4), 32'd1);
        chk("lat_vld",  32'(vld4), 32'd1);
        chk("lat_data", 32'(od4),  32'h00);
        send_token(1, 8'hFF, 1'b0);
        wait_ack(1, 1'b0, "ack_ff");
        send_token(1, 8'h3C, 1'b1);
        wait_ack(1, 1'b1, "ack_3c");
        drain(1, "drain_b2b");
        chk("tog_b2b", 32'(tog4), 32'd3);
        chk("ack_end_b2b", 32'(ack4), 32'd1);

        // Skewed 0xA5 on DEPTH=2 produces exactly one push.
        @(posedge clk); #1 rdy2 = 1'b0;
        base = tog2;
        send_token(0, 8'hA5, 1'b1);
        wait_ack(0, 1'b1, "ack_a5");
        chk("a5_vld",  32'(vld2), 32'd1);
        chk("a5_data", 32'(od2),  32'hA5);
        repeat (6) @(negedge clk);
        chk("a5_once", 32'(tog2 - base), 32'd1);
        chk("a5_stable", 32'(od2), 32'hA5);
        drain(0, "drain_a5");

        // Back-pressure: third token must be held until the consumer pops.
        @(posedge clk); #1 rdy2 = 1'b0;
        base = tog2;
        send_token(0, 8'h11, 1'b0);
        wait_ack(0, 1'b0, "ack_bp1");
        send_token(0, 8'h22, 1'b1);
        wait_ack(0, 1'b1, "ack_bp2");
        send_token(0, 8'h33, 1'b0);
        repeat (15) @(negedge clk);
        chk("bp_ack_held", 32'(ack2), 32'd1);
        chk("bp_tog",      32'(tog2 - base), 32'd2);
        chk("bp_head",     32'(od2), 32'h11);
        chk("bp_vld",      32'(vld2), 32'd1);
        @(posedge clk); #1 rdy2 = 1'b1;
        wait_ack(0, 1'b0, "ack_bp3");
        drain(0, "drain_bp");
        chk("bp_tog_all", 32'(tog2 - base), 32'd3);

        // Protocol error: both rails of bit 4 move; buffered token must still drain.
        @(posedge clk); #1 rdy2 = 1'b0;
        send_token(0, 8'h5A, 1'b0);
        wait_ack(0, 1'b1, "ack_5a");
        ack_before = ack2;
        @(posedge clk); #1 tx2[4] = ~tx2[4];
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_set", 32'(err2), 32'd1);
        repeat (5) @(negedge clk);
        chk("err_ack_frozen", 32'(ack2), 32'(ack_before));
        chk("err_head", 32'(od2), 32'h5A);
        drain(0, "drain_err");
        chk("err_sticky", 32'(err2), 32'd1);

        // Reset in the middle of a half-sent token.
        @(posedge clk); #1 rdy4 = 1'b0;
        toggle_bits(1, 8'hFF, 8'h0F);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack2",  32'(ack2), 32'd0);
        chk("mid_rst_err2",  32'(err2), 32'd0);
        chk("mid_rst_vld2",  32'(vld2), 32'd0);
        chk("mid_rst_ack4",  32'(ack4), 32'd0);
        chk("mid_rst_vld4",  32'(vld4), 32'd0);
        chk("mid_rst_data4", 32'(od4),  32'd0);
        tx2 = '0;
        tx4 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_token(1, 8'hC3, 1'b1);
        wait_ack(1, 1'b1, "ack_c3");
        chk("c3_data", 32'(od4), 32'hC3);
        drain(1, "drain_c3");

        // Nine tokens through DEPTH=4 with a randomly stalling consumer.
        base = tog4;
        fork
            begin
                logic ea;
                for (int i = 0; i < 9; i++) begin
                    ea = ~ack4;
                    send_token(1, vec[i], bit'(i % 2));
                    wait_ack(1, ea, "ack_wrap");
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rdy4 = 1'($urandom_range(0, 1));
                end
            end
        join
        drain(1, "drain_wrap");
        chk("wrap_tog", 32'(tog4 - base), 32'd9);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
